// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: imem req/ack port, execute redirect inputs, decode output.
// Carries misalign_err only when FETCH_MISALIGN_TRAP_EN is defined.
interface fetch_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [31:0]      imem_rdata;

  logic             redirect_valid;
  logic [1:0]       redirect_sel;
  logic [WIDTH-1:0] redirect_base;
  logic [31:0]      redirect_imm;
  logic [WIDTH-1:0] redirect_target;

  logic             stall;
  logic             instr_valid;
  logic [31:0]      instr;
  logic [WIDTH-1:0] instr_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic             misalign_err;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err,
    input  imem_ack, imem_rdata, redirect_valid, redirect_sel, redirect_base,
           redirect_imm, redirect_target, stall
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, misalign_err,
    output imem_ack, imem_rdata, redirect_valid, redirect_sel, redirect_base,
           redirect_imm, redirect_target, stall
  );
`else
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, redirect_valid, redirect_sel, redirect_base,
           redirect_imm, redirect_target, stall
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, redirect_valid, redirect_sel, redirect_base,
           redirect_imm, redirect_target, stall
  );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues one outstanding imem request, applies redirects.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect targets raise sticky misalign_err and park fetch.
module fetch_sequencer #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               rst,
  fetch_sequencer_if.master bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_nxt;
  logic             r_imem_req;
  logic             w_imem_req_nxt;
  logic             r_instr_valid;
  logic             w_instr_valid_nxt;
  logic [31:0]      r_instr;
  logic [31:0]      w_instr_nxt;
  logic [WIDTH-1:0] r_instr_pc;
  logic [WIDTH-1:0] w_instr_pc_nxt;

  logic             w_redirect;
  logic [WIDTH-1:0] w_target;
  logic             w_consumed;
  logic             w_trap;
  logic             w_parked;

  // Redirect decode; JALR target always has bit0 cleared.
  always_comb begin
    w_redirect = bus.redirect_valid &&
                 ((bus.redirect_sel == 2'b01) || (bus.redirect_sel == 2'b10));
    if (bus.redirect_sel == 2'b01) begin
      w_target = bus.redirect_base + WIDTH'($signed(bus.redirect_imm));
    end else begin
      w_target = bus.redirect_target & ~WIDTH'(1);
    end
  end

  assign w_consumed = r_instr_valid && !bus.stall;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign_err;

  assign w_parked = r_misalign_err;
  assign w_trap   = w_redirect && w_target[1] && !r_misalign_err;

  // Sticky until reset; once set the FSM stays parked in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign_err <= 1'b0;
    end else if (w_trap) begin
      r_misalign_err <= 1'b1;
    end
  end

  assign bus.misalign_err = r_misalign_err;
`else
  assign w_parked = 1'b0;
  assign w_trap   = 1'b0;
`endif

  // Next-state and next-output logic; redirect outranks ack and stall in every state.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_instr_valid_nxt = r_instr_valid;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;

    case (r_state)
      S_IDLE: begin
        if (!w_parked) begin
          if (w_redirect) begin
            w_pc_nxt = w_target;
          end
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = bus.imem_ack ? S_REQ : S_DISCARD;
        end else if (bus.imem_ack) begin
          w_instr_nxt       = bus.imem_rdata;
          w_instr_pc_nxt    = r_pc;
          w_instr_valid_nxt = 1'b1;
          w_pc_nxt          = r_pc + PC_STEP;
          w_state_nxt       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_redirect) begin
          w_instr_valid_nxt = 1'b0;
          w_pc_nxt          = w_target;
          w_state_nxt       = S_REQ;
        end else if (w_consumed) begin
          w_instr_valid_nxt = 1'b0;
          w_state_nxt       = S_REQ;
        end
      end
      S_DISCARD: begin
        // Stale response is swallowed; a redirect keeps only the newest target.
        if (w_redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = bus.imem_ack ? S_REQ : S_DISCARD;
        end else if (bus.imem_ack) begin
          w_state_nxt = S_REQ;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_trap) begin
      w_pc_nxt          = r_pc;
      w_instr_valid_nxt = 1'b0;
      w_state_nxt       = S_IDLE;
    end

    w_imem_req_nxt = (w_state_nxt == S_REQ);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_imem_req    <= w_imem_req_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
    end
  end

  assign bus.imem_req    = r_imem_req;
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = r_instr_valid;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: memory responder, instruction scoreboard,
// redirect vector table and hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_fetch_sequencer;
  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.WIDTH(WIDTH)) bus ();
  fetch_sequencer #(.WIDTH(WIDTH), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        rv;
    logic [1:0]  sel;
    logic [31:0] base;
    logic [31:0] imm;
    logic [31:0] tgt;
    logic        exp_redir;
    logic        misal;
    logic [31:0] exp_addr;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] exp_addr_q[$];
  vec_t        vecs[10];

  int n_checks = 0;
  int n_errors = 0;

  bit          m_pend = 1'b0;
  logic [31:0] m_addr;
  int          m_cnt, m_dly;
  int          ack_delay = 0;

  logic        prev_valid = 1'b0;
  logic        prev_req   = 1'b0;
  logic        prev_ack   = 1'b0;
  logic [31:0] prev_addr  = '0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample just after the edge, score outputs, then drive the memory response.
  task automatic tick();
    exp_t        e;
    logic [31:0] ea;
    @(posedge clk);
    #1;
    if (bus.instr_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_instr: got pc %h instr %h expected none", bus.instr_pc, bus.instr);
      end else begin
        e = exp_q.pop_front();
        chk("instr_pc", bus.instr_pc, e.pc);
        chk("instr", bus.instr, e.data);
      end
    end
    if (bus.instr_valid === 1'b1) chk("valid_with_req", 32'(bus.imem_req), 32'h0);
    if (prev_req && !prev_ack && bus.imem_req === 1'b1) chk("addr_stable", bus.imem_addr, prev_addr);

    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    if (!m_pend && bus.imem_req === 1'b1) begin
      m_pend = 1'b1;
      m_addr = bus.imem_addr;
      m_cnt  = 0;
      m_dly  = ack_delay;
      if (exp_addr_q.size() > 0) begin
        ea = exp_addr_q.pop_front();
        chk("req_addr", bus.imem_addr, ea);
      end
    end
    if (m_pend) begin
      if (m_cnt == m_dly) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = data_of(m_addr);
        m_pend         = 1'b0;
      end else begin
        m_cnt++;
      end
    end
    prev_valid = bus.instr_valid;
    prev_req   = bus.imem_req;
    prev_ack   = bus.imem_ack;
    prev_addr  = bus.imem_addr;
  endtask

  task automatic clear_redirect();
    bus.redirect_valid  = 1'b0;
    bus.redirect_sel    = 2'b00;
    bus.redirect_base   = '0;
    bus.redirect_imm    = '0;
    bus.redirect_target = '0;
  endtask

  task automatic drive_redirect(input logic [1:0] sel, input logic [31:0] base,
                                input logic [31:0] imm, input logic [31:0] tgt);
    bus.redirect_valid  = 1'b1;
    bus.redirect_sel    = sel;
    bus.redirect_base   = base;
    bus.redirect_imm    = imm;
    bus.redirect_target = tgt;
  endtask

  // One reset cycle; clear_mem=0 keeps an in-flight memory response alive across reset.
  task automatic do_reset(input bit clear_mem);
    rst = 1'b1;
    bus.stall = 1'b0;
    clear_redirect();
    exp_q.delete();
    exp_addr_q.delete();
    ack_delay = 0;
    if (clear_mem) begin
      m_pend       = 1'b0;
      bus.imem_ack = 1'b0;
    end
    tick();
    chk("rst_req", 32'(bus.imem_req), 32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_misalign", 32'(bus.misalign_err), 32'h0);
`endif
    rst = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.data = data_of(pc);
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input logic [31:0] pc, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      if (bus.instr_valid === 1'b1 && bus.instr_pc === pc) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_errors++;
      $display("FAIL wait_valid: pc %h not presented within %0d cycles", pc, budget);
    end
  endtask

  task automatic wait_req(input logic [31:0] addr, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      if (bus.imem_req === 1'b1 && bus.imem_addr === addr) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_errors++;
      $display("FAIL wait_req: addr %h not requested within %0d cycles", addr, budget);
    end
  endtask

  task automatic sb_done(input string name);
    chk(name, 32'(exp_q.size()), 32'h0);
  endtask

  // Fetch 0 and 4, then hold the request for 8 with a 3-cycle memory latency.
  task automatic reach_req8();
    do_reset(1'b1);
    push_exp(32'h0);
    push_exp(32'h4);
    wait_valid(32'h0, 10);
    wait_valid(32'h4, 10);
    ack_delay = 3;
    wait_req(32'h8, 10);
    ack_delay = 0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'b01, 32'h0000_0004, 32'h0000_0100, 32'h0000_2000, 1'b1, 1'b0, 32'h0000_0104};
    vecs[1] = '{1'b1, 2'b01, 32'h0000_0100, 32'hFFFF_FFF8, 32'h0000_2000, 1'b1, 1'b0, 32'h0000_00F8};
    vecs[2] = '{1'b1, 2'b01, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_2000, 1'b1, 1'b0, 32'h0000_0004};
    vecs[3] = '{1'b1, 2'b10, 32'h0000_0040, 32'h0000_0040, 32'h0000_2001, 1'b1, 1'b0, 32'h0000_2000};
    vecs[4] = '{1'b1, 2'b10, 32'h0000_0040, 32'h0000_0040, 32'h0000_3000, 1'b1, 1'b0, 32'h0000_3000};
    vecs[5] = '{1'b1, 2'b00, 32'h0000_0040, 32'h0000_0040, 32'h0000_2000, 1'b0, 1'b0, 32'h0000_0004};
    vecs[6] = '{1'b1, 2'b11, 32'h0000_0040, 32'h0000_0040, 32'h0000_2000, 1'b0, 1'b0, 32'h0000_0004};
    vecs[7] = '{1'b0, 2'b01, 32'h0000_0004, 32'h0000_0100, 32'h0000_2000, 1'b0, 1'b0, 32'h0000_0004};
    vecs[8] = '{1'b1, 2'b01, 32'h0000_0100, 32'h0000_0002, 32'h0000_2000, 1'b1, 1'b1, 32'h0000_0102};
    vecs[9] = '{1'b1, 2'b10, 32'h0000_0040, 32'h0000_0040, 32'h0000_1003, 1'b1, 1'b1, 32'h0000_1002};

    rst            = 1'b1;
    bus.stall      = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    clear_redirect();

    // Zero-wait streaming: 0,4,8,C with one-cycle valid pulses.
    do_reset(1'b1);
    for (int k = 0; k < 4; k++) begin
      push_exp(32'(4 * k));
      exp_addr_q.push_back(32'(4 * k));
    end
    for (int k = 0; k < 4; k++) begin
      wait_valid(32'(4 * k), 10);
      tick();
      chk("valid_pulse", 32'(bus.instr_valid), 32'h0);
    end
    sb_done("sb_stream");
    chk("addr_q_stream", 32'(exp_addr_q.size()), 32'h0);

    // Stall for 5 cycles while holding pc 4.
    do_reset(1'b1);
    push_exp(32'h0);
    push_exp(32'h4);
    wait_valid(32'h0, 10);
    wait_valid(32'h4, 10);
    bus.stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_valid", 32'(bus.instr_valid), 32'h1);
      chk("stall_pc", bus.instr_pc, 32'h4);
      chk("stall_instr", bus.instr, data_of(32'h4));
      chk("stall_req", 32'(bus.imem_req), 32'h0);
      chk("stall_addr", bus.imem_addr, 32'h8);
    end
    bus.stall = 1'b0;
    tick();
    chk("unstall_req", 32'(bus.imem_req), 32'h1);
    chk("unstall_addr", bus.imem_addr, 32'h8);
    chk("unstall_valid", 32'(bus.instr_valid), 32'h0);

    // Redirect during a slow request: stale response discarded, refetch at 0x104.
    reach_req8();
    drive_redirect(2'b01, 32'h4, 32'h100, 32'h0);
    tick();
    clear_redirect();
    chk("disc_req", 32'(bus.imem_req), 32'h0);
    chk("disc_addr", bus.imem_addr, 32'h104);
    chk("disc_valid", 32'(bus.instr_valid), 32'h0);
    push_exp(32'h104);
    tick();
    chk("disc_req2", 32'(bus.imem_req), 32'h0);
    tick();
    chk("disc_req3", 32'(bus.imem_req), 32'h0);
    tick();
    chk("refetch_req", 32'(bus.imem_req), 32'h1);
    chk("refetch_addr", bus.imem_addr, 32'h104);
    wait_valid(32'h104, 5);
    sb_done("sb_discard");

    // Second redirect in DISCARD, then a redirect coinciding with the stale ack.
    reach_req8();
    drive_redirect(2'b01, 32'h4, 32'h100, 32'h0);
    tick();
    drive_redirect(2'b10, 32'h0, 32'h0, 32'h501);
    tick();
    clear_redirect();
    chk("disc2_req", 32'(bus.imem_req), 32'h0);
    chk("disc2_addr", bus.imem_addr, 32'h500);
    tick();
    chk("disc2_ack_cycle_req", 32'(bus.imem_req), 32'h0);
    drive_redirect(2'b10, 32'h0, 32'h0, 32'h701);
    tick();
    clear_redirect();
    chk("disc2_req_after", 32'(bus.imem_req), 32'h1);
    chk("disc2_addr_after", bus.imem_addr, 32'h700);
    push_exp(32'h700);
    wait_valid(32'h700, 5);
    sb_done("sb_discard2");

    // JALR redirect in the same cycle as the ack: data dropped, fetch at 0x2000.
    do_reset(1'b1);
    push_exp(32'h0);
    wait_valid(32'h0, 10);
    tick();
    chk("jalr_pre_req", 32'(bus.imem_req), 32'h1);
    chk("jalr_pre_addr", bus.imem_addr, 32'h4);
    drive_redirect(2'b10, 32'h0, 32'h0, 32'h2001);
    tick();
    clear_redirect();
    chk("jalr_req", 32'(bus.imem_req), 32'h1);
    chk("jalr_addr", bus.imem_addr, 32'h2000);
    chk("jalr_valid", 32'(bus.instr_valid), 32'h0);
    push_exp(32'h2000);
    wait_valid(32'h2000, 5);
    sb_done("sb_jalr");

    // Reset mid-request; the late ack lands in IDLE and must be ignored.
    do_reset(1'b1);
    ack_delay = 1;
    wait_req(32'h0, 5);
    do_reset(1'b0);
    chk("late_ack_seen", 32'(bus.imem_ack), 32'h1);
    tick();
    chk("restart_req", 32'(bus.imem_req), 32'h1);
    chk("restart_addr", bus.imem_addr, 32'h0);
    chk("restart_valid", 32'(bus.instr_valid), 32'h0);
    push_exp(32'h0);
    wait_valid(32'h0, 5);
    sb_done("sb_restart");

    // pc+4 wraps past the top of the address space.
    do_reset(1'b1);
    push_exp(32'h0);
    wait_valid(32'h0, 10);
    drive_redirect(2'b10, 32'h0, 32'h0, 32'hFFFF_FFFC);
    push_exp(32'hFFFF_FFFC);
    push_exp(32'h0);
    exp_addr_q.push_back(32'hFFFF_FFFC);
    exp_addr_q.push_back(32'h0);
    tick();
    clear_redirect();
    wait_valid(32'hFFFF_FFFC, 6);
    wait_valid(32'h0, 6);
    sb_done("sb_wrap");

    // Redirect target table applied from HOLD under stall.
    for (int i = 0; i < 10; i++) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (vecs[i].misal) continue;
`endif
      do_reset(1'b1);
      bus.stall = 1'b1;
      push_exp(32'h0);
      wait_valid(32'h0, 10);
      bus.redirect_valid  = vecs[i].rv;
      bus.redirect_sel    = vecs[i].sel;
      bus.redirect_base   = vecs[i].base;
      bus.redirect_imm    = vecs[i].imm;
      bus.redirect_target = vecs[i].tgt;
      tick();
      clear_redirect();
      chk($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_req", i), 32'(bus.imem_req), 32'(vecs[i].exp_redir));
      chk($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 32'(!vecs[i].exp_redir));
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned branch target: sticky error, fetch parked, pc frozen.
    do_reset(1'b1);
    bus.stall = 1'b1;
    push_exp(32'h0);
    wait_valid(32'h0, 10);
    drive_redirect(2'b01, 32'h100, 32'h2, 32'h0);
    tick();
    drive_redirect(2'b10, 32'h0, 32'h0, 32'h2000);
    chk("trap_err", 32'(bus.misalign_err), 32'h1);
    chk("trap_valid", 32'(bus.instr_valid), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 1) clear_redirect();
      chk("trap_req", 32'(bus.imem_req), 32'h0);
      chk("trap_addr", bus.imem_addr, 32'h4);
      chk("trap_err_sticky", 32'(bus.misalign_err), 32'h1);
    end
    do_reset(1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
